conv_window_accumulator: RTL
============================

Name: conv_window_accumulator

Overview:
- Sequential consumer of the team's 32-bit carry-select adder (Select_32Bit).
- Accepts a stream of 32-bit partial products, one per handshake beat, and accumulates exactly TAPS beats per window through the adder.
- Presents each window sum with a sticky carry/overflow flag to the downstream convolution output stage.
- Sits between the product stream and the output writer of the convolution datapath.

Parameters:
- TAPS, 9, beats per window (3x3 kernel); legal range 1..255.
- CNT_W, 8, beat-counter width; must satisfy 2^CNT_W > TAPS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of the current window.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  32  partial product.
- out_valid  out  1  window result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  32  window sum (mod 2^32, or clamped with the optional feature).
- out_carry  out  1  OR of adder Cout over all beats of the window.
- beat_cnt  out  CNT_W  beats accepted in the current window.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: in_ready=0 during reset, 1 on the first edge after release; out_valid=0, out_sum=0, out_carry=0, beat_cnt=0; state=IDLE.
- Datapath: one Select_32Bit instance. A = (beat_cnt==0) ? 0 : acc; B = in_data. Uses S and Cout; S_Alt and Cout_Alt are left unused.
- Beat accept: accept = in_valid & in_ready.
- On accept: acc <= S; carry_acc <= (beat_cnt==0 ? 0 : carry_acc) | Cout; beat_cnt increments.
- States:
  - IDLE: in_ready=1, beat_cnt=0. Accept -> ACCUM; if TAPS==1 -> HOLD.
  - ACCUM: in_ready=1. Accept of beat TAPS (beat_cnt==TAPS-1) -> HOLD; beat_cnt returns to 0.
  - HOLD: out_valid=1; out_sum and out_carry are stable and registered. in_ready = out_ready.
    - out_valid & out_ready with no accept -> IDLE.
    - With a same-cycle accept -> ACCUM (or HOLD if TAPS==1). That beat starts the next window from A=0.
- Latency: out_valid rises on the edge that accepts beat TAPS. Result is visible the cycle after the last beat.
- Throughput: one beat per cycle. No bubble between windows when out_ready is held high.
- Backpressure: in HOLD with out_ready=0, in_ready=0 and the result holds indefinitely.
- clear:
  - clear=1 forces beat_cnt=0 and state IDLE on the next edge, and discards any beat presented that cycle.
  - A result in HOLD is also dropped (out_valid=0).
  - clear has priority over every other event.
- Wrap: the sum wraps mod 2^32 and out_carry records that the wrap happened. The carry is never folded back into the sum.
- rst_n asserted mid-window or in HOLD: all state returns to reset values immediately; no partial result is emitted.

Optional Feature:
- Macro: CONV_ACC_SATURATE_EN.
- Defined: once carry_acc is set, the stored acc is forced to 32'hFFFFFFFF for the rest of the window. out_sum is 32'hFFFFFFFF whenever out_carry=1.
- Undefined: modular sum as described in Behaviour.
- out_carry behaves identically either way.

Decomposition:
- Package conv_pkg:
  - DATA_W=32.
  - Default TAPS=9.
  - State enum {IDLE, ACCUM, HOLD}.
  - SAT_VAL=32'hFFFFFFFF.
- Sub-module: reuse Select_32Bit as the adder. No new sub-module.

Test Plan:
- TAPS=9, nine beats of 32'h1, out_ready=1 -> out_sum=9, out_carry=0, out_valid one cycle after beat 9.
- TAPS=2, beats 32'hFFFFFFFF then 32'h1 -> out_sum=0, out_carry=1. With CONV_ACC_SATURATE_EN defined -> out_sum=32'hFFFFFFFF.
- TAPS=2, beats 32'h12345678 and 32'h98765432 -> out_sum=32'hAAAAAAAA, carry=0.
  - Then hold out_ready=0 for 5 cycles: in_ready=0, result stable.
  - Then raise out_ready with in_valid high: result accepted and a new beat accepted in the same cycle.
- TAPS=9, clear pulsed after beat 4, then nine beats of 32'h2 -> out_sum=18 (no residue from the aborted window).
- rst_n low for 1 cycle mid-window after beat 5 -> all outputs 0; the next nine beats of 32'h1 yield out_sum=9.
- Back-to-back windows with in_valid=1 and out_ready=1 continuously -> out_valid pulses every TAPS cycles, no dropped beats.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window accumulator.
package conv_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned TAPS_DEFAULT = 9;
  localparam logic [DATA_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } accState_e;

endpackage

// File: rtl/Select_32Bit.sv
// 32-bit carry-select adder: the low half ripples, and the high half is
// precomputed for both carry-ins and then selected. S/Cout assume carry-in 0.
// S_Alt/Cout_Alt assume carry-in 1.
module Select_32Bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] S,
  output logic        Cout,
  output logic [31:0] S_Alt,
  output logic        Cout_Alt
);

  logic [16:0] lo0, lo1, hi0, hi1;

  // Form both candidate sums for each half, then select the high half using the low-half carry
  always_comb begin
    lo0      = {1'b0, A[15:0]}  + {1'b0, B[15:0]};
    lo1      = {1'b0, A[15:0]}  + {1'b0, B[15:0]}  + 17'd1;
    hi0      = {1'b0, A[31:16]} + {1'b0, B[31:16]};
    hi1      = {1'b0, A[31:16]} + {1'b0, B[31:16]} + 17'd1;
    S        = {(lo0[16] ? hi1[15:0] : hi0[15:0]), lo0[15:0]};
    Cout     = lo0[16] ? hi1[16] : hi0[16];
    S_Alt    = {(lo1[16] ? hi1[15:0] : hi0[15:0]), lo1[15:0]};
    Cout_Alt = lo1[16] ? hi1[16] : hi0[16];
  end

endmodule

// File: rtl/conv_window_accumulator.sv
// Accumulates TAPS partial products per window through Select_32Bit and
// presents each window sum with a sticky carry flag.
// Optional macro CONV_ACC_SATURATE_EN: clamp the stored sum to all-ones once
// the window has carried.
module conv_window_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned TAPS  = TAPS_DEFAULT,
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic [CNT_W-1:0]  beat_cnt
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TAPS - 1);

  accState_e         state, stateNext;
  logic              readyEn;
  logic [DATA_W-1:0] acc, addA, addS, nextAcc;
  logic              addCout, carryAcc, nextCarry;
  logic              accept, firstBeat, lastBeat;
  logic [DATA_W-1:0] unusedSAlt;
  logic              unusedCoutAlt;

  assign firstBeat = (beat_cnt == '0);
  assign lastBeat  = (beat_cnt == LAST_BEAT);
  assign addA      = firstBeat ? '0 : acc;
  assign accept    = in_valid & in_ready & ~clear;
  assign nextCarry = (firstBeat ? 1'b0 : carryAcc) | addCout;

`ifdef CONV_ACC_SATURATE_EN
  assign nextAcc = nextCarry ? SAT_VAL : addS;
`else
  assign nextAcc = addS;
`endif

  Select_32Bit adder (
    .A        (addA),
    .B        (in_data),
    .S        (addS),
    .Cout     (addCout),
    .S_Alt    (unusedSAlt),
    .Cout_Alt (unusedCoutAlt)
  );

  // Next-state and handshake outputs; clear overrides all other events
  always_comb begin
    stateNext = state;
    out_valid = (state == HOLD);
    in_ready  = readyEn & ((state != HOLD) | out_ready);
    if (clear) begin
      stateNext = IDLE;
    end else if (accept) begin
      stateNext = lastBeat ? HOLD : ACCUM;
    end else if ((state == HOLD) && out_ready) begin
      stateNext = IDLE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readyEn <= 1'b0;
    end else begin
      readyEn <= 1'b1;
    end
  end

  // Accumulator, beat counter and result registers; the result is copied out
  // separately so a beat accepted during HOLD can start the next window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      carryAcc  <= 1'b0;
      beat_cnt  <= '0;
      out_sum   <= '0;
      out_carry <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
    end else if (accept) begin
      acc      <= nextAcc;
      carryAcc <= nextCarry;
      beat_cnt <= lastBeat ? '0 : beat_cnt + CNT_W'(1);
      if (lastBeat) begin
        out_sum   <= nextAcc;
        out_carry <= nextCarry;
      end
    end
  end

endmodule
